// File: rtl/seq_pkg.sv
// Shared types and constants for the program load-and-run sequencer.
// The optional load checksum is enabled by defining SEQ_LOAD_CHECKSUM_EN.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  localparam int SEQ_ADDR_W = 7;
  localparam int SEQ_DATA_W = 32;

  // The computer's reset and enable are both active-low.
  localparam logic COMP_RST_ASSERT   = 1'b0;
  localparam logic COMP_RST_DEASSERT = 1'b1;
  localparam logic COMP_EN_RUN       = 1'b0;
  localparam logic COMP_EN_FREEZE    = 1'b1;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: a one-cycle pulse on rise_o one clock after sig_i rises.
module edge_detect_rise (
  input  logic clk,
  input  logic reset_sm,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge reset_sm) begin
    if (!reset_sm) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/program_run_sequencer.sv
// Streams a program into instruction memory with the computer held in reset, then runs it
// for a bounded budget or single-steps it. Define SEQ_LOAD_CHECKSUM_EN for the load checksum.
module program_run_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W    = SEQ_ADDR_W,
  parameter int DATA_W    = SEQ_DATA_W,
  parameter int MAX_INSTR = 128,
  parameter int CYC_W     = 16
) (
  input  logic              clk,
  input  logic              reset_sm,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic [CYC_W-1:0]  run_limit,
  input  logic              halt,
  output logic              comp_rst,
  output logic              comp_en,
  output logic              wr_instr_en,
  output logic [ADDR_W-1:0] wr_instr_addr,
  output logic [DATA_W-1:0] wr_instr,
  output logic [ADDR_W:0]   n_loaded,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0]  MaxCnt = MAX_INSTR[ADDR_W:0];
  localparam logic [ADDR_W:0]  CntOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CycOne = {{(CYC_W-1){1'b0}}, 1'b1};

  seq_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CYC_W-1:0]  limit_q, limit_d;
  logic              step_q, step_d;
  logic              comp_rst_q, comp_rst_d;
  logic              comp_en_q, comp_en_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   n_loaded_q, n_loaded_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic              step_rise;
  logic              start_fire;
  logic              beat;
  logic              run_exit;

  edge_detect_rise u_step_edge (
    .clk      (clk),
    .reset_sm (reset_sm),
    .sig_i    (step_req),
    .rise_o   (step_rise)
  );

  assign start_fire = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign beat       = (state_q == ST_LOAD) && in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cyc_d      = cyc_q;
    limit_d    = limit_q;
    step_d     = step_q;
    comp_rst_d = comp_rst_q;
    comp_en_d  = comp_en_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    n_loaded_d = n_loaded_q;
    done_d     = done_q;
    halted_d   = halted_q;
    error_d    = error_q;
    run_exit   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        comp_en_d = COMP_EN_FREEZE;
        if (start_fire) begin
          state_d    = ST_LOAD;
          count_d    = '0;
          done_d     = 1'b0;
          halted_d   = 1'b0;
          error_d    = 1'b0;
          limit_d    = run_limit;
          step_d     = step_mode;
          comp_rst_d = COMP_RST_ASSERT;
        end
      end

      ST_LOAD: begin
        comp_rst_d = COMP_RST_ASSERT;
        comp_en_d  = COMP_EN_FREEZE;
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_W-1:0];
          wr_data_d = in_data;
          count_d   = count_q + CntOne;
          if (in_last) begin
            state_d    = ST_RELEASE;
            n_loaded_d = count_q + CntOne;
          end
        end else if (in_valid && (count_q == MaxCnt)) begin
          // Program longer than memory: abort without ever releasing the computer.
          error_d    = 1'b1;
          done_d     = 1'b1;
          n_loaded_d = count_q;
          state_d    = ST_DONE;
        end
      end

      ST_RELEASE: begin
        comp_rst_d = COMP_RST_DEASSERT;
        comp_en_d  = COMP_EN_FREEZE;
        cyc_d      = '0;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        // Exit is only judged at the end of a cycle in which the computer was enabled.
        if (comp_en_q == COMP_EN_RUN) begin
          if (halt || ((limit_q != '0) && (cyc_q == limit_q - CycOne))) begin
            run_exit  = 1'b1;
            state_d   = ST_DONE;
            done_d    = 1'b1;
            halted_d  = halt;
            comp_en_d = COMP_EN_FREEZE;
          end else if (cyc_q != '1) begin
            cyc_d = cyc_q + CycOne;
          end
        end
        if (!run_exit) begin
          comp_en_d = (step_q && !step_rise) ? COMP_EN_FREEZE : COMP_EN_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD) && (count_d < MaxCnt);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_sm) begin
    if (!reset_sm) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      cyc_q      <= '0;
      limit_q    <= '0;
      step_q     <= 1'b0;
      comp_rst_q <= COMP_RST_ASSERT;
      comp_en_q  <= COMP_EN_FREEZE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      n_loaded_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      limit_q    <= limit_d;
      step_q     <= step_d;
      comp_rst_q <= comp_rst_d;
      comp_en_q  <= comp_en_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      n_loaded_q <= n_loaded_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

`ifdef SEQ_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset_sm) begin
    if (!reset_sm) begin
      sum_q <= '0;
    end else if (start_fire) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign comp_rst      = comp_rst_q;
  assign comp_en       = comp_en_q;
  assign in_ready      = in_ready_q;
  assign wr_instr_en   = wr_en_q;
  assign wr_instr_addr = wr_addr_q;
  assign wr_instr      = wr_data_q;
  assign n_loaded      = n_loaded_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign halted        = halted_q;
  assign error         = error_q;

endmodule

// File: tb/tb_program_run_sequencer.sv
// Self-checking bench for program_run_sequencer (small MAX_INSTR so overflow is reachable).
module tb_program_run_sequencer;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int MAX_INSTR = 4;
  localparam int CYC_W     = 16;

  logic              clk = 1'b0;
  logic              reset_sm;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              step_mode;
  logic              step_req;
  logic [CYC_W-1:0]  run_limit;
  logic              halt;
  logic              comp_rst;
  logic              comp_en;
  logic              wr_instr_en;
  logic [ADDR_W-1:0] wr_instr_addr;
  logic [DATA_W-1:0] wr_instr;
  logic [ADDR_W:0]   n_loaded;
  logic              busy;
  logic              done;
  logic              halted;
  logic              error;
  logic [DATA_W-1:0] checksum;

  int          nAsserts = 0;
  int          nFail    = 0;
  logic [31:0] progWords[8];
  int          progLen;

  program_run_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_INSTR(MAX_INSTR), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset_sm(reset_sm), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .step_mode(step_mode), .step_req(step_req), .run_limit(run_limit), .halt(halt),
    .comp_rst(comp_rst), .comp_en(comp_en),
    .wr_instr_en(wr_instr_en), .wr_instr_addr(wr_instr_addr), .wr_instr(wr_instr),
    .n_loaded(n_loaded), .busy(busy), .done(done), .halted(halted), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expectedSum();
    logic [31:0] s = 32'd0;
`ifdef SEQ_LOAD_CHECKSUM_EN
    for (int i = 0; i < progLen; i++) s = s + progWords[i];
`endif
    return s;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_comp_rst"}, comp_rst, 0);
    checkOutput({tag, "_comp_en"}, comp_en, 1);
    checkOutput({tag, "_wr_en"}, wr_instr_en, 0);
    checkOutput({tag, "_wr_addr"}, wr_instr_addr, 0);
    checkOutput({tag, "_wr_data"}, wr_instr, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_n_loaded"}, n_loaded, 0);
    checkOutput({tag, "_flags"}, {busy, done, halted, error}, 4'b0000);
    checkOutput({tag, "_checksum"}, checksum, 0);
  endtask

  // Start, stream progWords[0..progLen-1] back to back, and check the writes and release cycle.
  task automatic applyStimulus(input logic [CYC_W-1:0] limit, input bit stepMode);
    start = 1'b1; step_mode = stepMode; run_limit = limit;
    tick();
    start = 1'b0;
    checkOutput("load_busy", busy, 1);
    checkOutput("load_in_ready", in_ready, 1);
    for (int i = 0; i < progLen; i++) begin
      in_valid = 1'b1; in_data = progWords[i]; in_last = (i == progLen - 1);
      tick();
      checkOutput($sformatf("write%0d_en", i), wr_instr_en, 1);
      checkOutput($sformatf("write%0d_addr", i), wr_instr_addr, i);
      checkOutput($sformatf("write%0d_data", i), wr_instr, progWords[i]);
      checkOutput($sformatf("write%0d_held", i), comp_rst, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    checkOutput("n_loaded", n_loaded, progLen);
    tick();
    checkOutput("release_state", {comp_rst, comp_en, wr_instr_en}, 3'b110);
    checkOutput("load_checksum", checksum, expectedSum());
  endtask

  // Free run: count enabled cycles until done, raising halt in the haltAt-th one (0 = never).
  task automatic runFree(input int limit, input int haltAt);
    int  en = 0;
    bit  finished = 0;
    int  expEn;
    bit  expHalted;
    expHalted = (haltAt > 0) && ((limit == 0) || (haltAt <= limit));
    expEn     = expHalted ? haltAt : limit;
    for (int c = 0; c < 300 && !finished; c++) begin
      tick();
      halt = 1'b0;
      if (comp_en == 1'b0) begin
        en++;
        if (en == haltAt) halt = 1'b1;
      end
      if (done) finished = 1;
    end
    halt = 1'b0;
    checkOutput("run_terminated", finished, 1);
    checkOutput("run_enabled_cycles", en, expEn);
    checkOutput("run_halted", halted, expHalted);
    checkOutput("run_end_state", {comp_rst, comp_en, busy, error}, 4'b1100);
    checkOutput("run_checksum_held", checksum, expectedSum());
  endtask

  initial begin
    int en;
    int holds[3];
    reset_sm = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    step_mode = 1'b0; step_req = 1'b0; run_limit = '0; halt = 1'b0;
    #12;
    checkResetValues("reset");
    reset_sm = 1'b1;
    tick();
    checkOutput("idle_not_busy", busy, 0);

    $display("[TB] three-word program, budget 10");
    progLen = 3;
    progWords[0] = 32'h20080007; progWords[1] = 32'hAC080000; progWords[2] = 32'h00000000;
    applyStimulus(16'd10, 1'b0);
    runFree(10, 0);

    $display("[TB] unlimited run ended by halt on 5th cycle");
    applyStimulus(16'd0, 1'b0);
    runFree(0, 5);

    $display("[TB] checksum program 1, 2, 0xFFFFFFFF");
    progWords[0] = 32'h1; progWords[1] = 32'h2; progWords[2] = 32'hFFFFFFFF;
    applyStimulus(16'd1, 1'b0);
    runFree(1, 0);
`ifdef SEQ_LOAD_CHECKSUM_EN
    checkOutput("checksum_wrap", checksum, 32'h00000002);
`else
    checkOutput("checksum_off", checksum, 32'h0);
`endif

    $display("[TB] overflow with five words and no last");
    start = 1'b1; run_limit = 16'd5; step_mode = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + i; in_last = 1'b0;
      tick();
      checkOutput($sformatf("ovf_write%0d_addr", i), {wr_instr_en, wr_instr_addr}, {1'b1, 7'(i)});
    end
    checkOutput("ovf_in_ready_full", in_ready, 0);
    tick();
    in_valid = 1'b0;
    checkOutput("ovf_flags", {error, done, busy, wr_instr_en}, 4'b1100);
    repeat (3) tick();
    checkOutput("ovf_never_released", {comp_rst, comp_en}, 2'b01);

    $display("[TB] step mode, three pulses, budget 3");
    progLen = 2; progWords[0] = 32'h1234_5678; progWords[1] = 32'h9ABC_DEF0;
    applyStimulus(16'd3, 1'b1);
    holds[0] = 1; holds[1] = 4; holds[2] = 2;
    en = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      for (int h = 0; h < holds[p]; h++) begin
        tick();
        if (comp_en == 1'b0) en++;
      end
      step_req = 1'b0;
      for (int g = 0; g < 4; g++) begin
        tick();
        if (comp_en == 1'b0) en++;
      end
      if (p < 2) checkOutput($sformatf("step%0d_not_done", p), done, 0);
    end
    checkOutput("step_enabled_cycles", en, 3);
    checkOutput("step_done", {done, halted, comp_en}, 3'b101);

    $display("[TB] reset mid-run then reload");
    progLen = 2; progWords[0] = 32'hCAFE_0001; progWords[1] = 32'hCAFE_0002;
    applyStimulus(16'd0, 1'b0);
    repeat (4) tick();
    checkOutput("midrun_running", comp_en, 0);
    reset_sm = 1'b0;
    #1;
    checkResetValues("midrun_reset");
    #3;
    reset_sm = 1'b1;
    tick();
    applyStimulus(16'd2, 1'b0);
    runFree(2, 0);

    $display("[TB] randomized programs against reference model");
    for (int r = 0; r < 8; r++) begin
      int lim;
      int hAt;
      progLen = $urandom_range(1, MAX_INSTR);
      for (int i = 0; i < progLen; i++) progWords[i] = $urandom;
      lim = $urandom_range(0, 12);
      if (lim == 0) hAt = $urandom_range(1, 15);
      else hAt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lim + 3) : 0;
      applyStimulus(16'(lim), 1'b0);
      runFree(lim, hAt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
